// File: rtl/sign_extender_if.sv
// Immediate-extension bus: instruction field and format select in, combinational and
// registered extended immediates out.
interface sign_extender_if;
  logic [25:0] in26;
  logic [1:0]  ctrl;
  logic        en;
  logic [63:0] bus_imm;
  logic [63:0] bus_imm_q;
  logic [1:0]  ctrl_q;

  modport master (
    output in26,
    output ctrl,
    output en,
    input  bus_imm,
    input  bus_imm_q,
    input  ctrl_q
  );

  modport slave (
    input  in26,
    input  ctrl,
    input  en,
    output bus_imm,
    output bus_imm_q,
    output ctrl_q
  );
endinterface

// File: rtl/sign_extender.sv
// Extends the I/D/B/CB immediate fields of an instruction to 64 bits, with an optional
// registered copy that also records the format it was built from.
module sign_extender (
  input  logic            i_clk,
  input  logic            i_reset,
  sign_extender_if.slave  io_bus
);

  localparam logic [1:0] CtrlI  = 2'b00;
  localparam logic [1:0] CtrlD  = 2'b01;
  localparam logic [1:0] CtrlB  = 2'b10;
  localparam logic [1:0] CtrlCb = 2'b11;

  logic [63:0] w_imm;
  logic [63:0] r_imm_q;
  logic [1:0]  r_ctrl_q;

  // No format is scaled; word-offset shifting belongs to the consumer.
  always_comb begin
    w_imm = 64'h0;
    unique case (io_bus.ctrl)
      CtrlI:  w_imm = {52'h0, io_bus.in26[21:10]};
      CtrlD:  w_imm = {{55{io_bus.in26[20]}}, io_bus.in26[20:12]};
      CtrlB:  w_imm = {{38{io_bus.in26[25]}}, io_bus.in26[25:0]};
      CtrlCb: w_imm = {{45{io_bus.in26[23]}}, io_bus.in26[23:5]};
      default: w_imm = 64'h0;
    endcase
  end

  // Reset wins over a pending load on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_imm_q  <= 64'h0;
      r_ctrl_q <= 2'b00;
    end else if (io_bus.en) begin
      r_imm_q  <= w_imm;
      r_ctrl_q <= io_bus.ctrl;
    end
  end

  assign io_bus.bus_imm   = w_imm;
  assign io_bus.bus_imm_q = r_imm_q;
  assign io_bus.ctrl_q    = r_ctrl_q;

endmodule

// File: tb/tb_sign_extender.sv
// Directed bench for sign_extender: table of combinational vectors plus hand-written
// sequences for the registered copy, hold, and reset priority.
module tb_sign_extender;

  logic i_clk;
  logic i_reset;

  sign_extender_if ifc ();

  sign_extender dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .io_bus  (ifc.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [25:0] in26;
    logic [1:0]  ctrl;
    logic [63:0] exp;
  } vec_t;

  int checks;
  int failures;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check2(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  vec_t vecs[14];

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0]  = '{26'h0111A55, 2'b00, 64'h0000000000000446};
    vecs[1]  = '{26'h0311A55, 2'b00, 64'h0000000000000C46};
    vecs[2]  = '{26'h3C003FF, 2'b00, 64'h0000000000000000};
    vecs[3]  = '{26'h0111A55, 2'b01, 64'hFFFFFFFFFFFFFF11};
    vecs[4]  = '{26'h0011A55, 2'b01, 64'h0000000000000011};
    vecs[5]  = '{26'h3E00FFF, 2'b01, 64'h0000000000000000};
    vecs[6]  = '{26'h0111A55, 2'b10, 64'h0000000000111A55};
    vecs[7]  = '{26'h2111A55, 2'b10, 64'hFFFFFFFFFE111A55};
    vecs[8]  = '{26'h2000000, 2'b10, 64'hFFFFFFFFFE000000};
    vecs[9]  = '{26'h0111A55, 2'b11, 64'h00000000000088D2};
    vecs[10] = '{26'h0911A55, 2'b11, 64'hFFFFFFFFFFFC88D2};
    vecs[11] = '{26'h300001F, 2'b11, 64'h0000000000000000};
    vecs[12] = '{26'h0800000, 2'b11, 64'hFFFFFFFFFFFC0000};
    vecs[13] = '{26'h0200000, 2'b00, 64'h0000000000000800};

    i_reset  = 1'b1;
    ifc.en   = 1'b0;
    ifc.ctrl = 2'b00;
    ifc.in26 = 26'h0;
    tick();
    check64("reset_imm_q", ifc.bus_imm_q, 64'h0);
    check2("reset_ctrl_q", ifc.ctrl_q, 2'b00);

    // Combinational table with En low; the registered copy must not move.
    i_reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      ifc.in26 = vecs[i].in26;
      ifc.ctrl = vecs[i].ctrl;
      #1;
      check64($sformatf("comb_vec%0d", i), ifc.bus_imm, vecs[i].exp);
      tick();
    end
    check64("hold_after_table", ifc.bus_imm_q, 64'h0);
    check2("hold_ctrl_after_table", ifc.ctrl_q, 2'b00);

    // Load B-type.
    ifc.en   = 1'b1;
    ifc.ctrl = 2'b10;
    ifc.in26 = 26'h2111A55;
    tick();
    check64("load_b_imm_q", ifc.bus_imm_q, 64'hFFFFFFFFFE111A55);
    check2("load_b_ctrl_q", ifc.ctrl_q, 2'b10);

    // Inputs change mid-cycle: only the next edge may capture them.
    ifc.en   = 1'b0;
    ifc.ctrl = 2'b01;
    ifc.in26 = 26'h0111A55;
    #1;
    check64("mid_cycle_imm_q", ifc.bus_imm_q, 64'hFFFFFFFFFE111A55);
    check64("mid_cycle_comb", ifc.bus_imm, 64'hFFFFFFFFFFFFFF11);
    tick();
    check64("en0_hold_imm_q", ifc.bus_imm_q, 64'hFFFFFFFFFE111A55);
    check2("en0_hold_ctrl_q", ifc.ctrl_q, 2'b10);

    // Reset together with En: reset wins, comb path still tracks inputs.
    i_reset  = 1'b1;
    ifc.en   = 1'b1;
    ifc.ctrl = 2'b11;
    ifc.in26 = 26'h0911A55;
    tick();
    check64("rst_en_imm_q", ifc.bus_imm_q, 64'h0);
    check2("rst_en_ctrl_q", ifc.ctrl_q, 2'b00);
    check64("rst_en_comb", ifc.bus_imm, 64'hFFFFFFFFFFFC88D2);

    // After reset, nothing loads until an edge with En high.
    i_reset = 1'b0;
    ifc.en  = 1'b0;
    tick();
    check64("post_rst_idle", ifc.bus_imm_q, 64'h0);
    ifc.en   = 1'b1;
    ifc.ctrl = 2'b01;
    ifc.in26 = 26'h0111A55;
    tick();
    check64("post_rst_load_imm_q", ifc.bus_imm_q, 64'hFFFFFFFFFFFFFF11);
    check2("post_rst_load_ctrl_q", ifc.ctrl_q, 2'b01);

    // Back-to-back loads.
    ifc.ctrl = 2'b00;
    ifc.in26 = 26'h0311A55;
    tick();
    check64("b2b_load_imm_q", ifc.bus_imm_q, 64'h0000000000000C46);
    check2("b2b_load_ctrl_q", ifc.ctrl_q, 2'b00);
    ifc.ctrl = 2'b11;
    ifc.in26 = 26'h0111A55;
    tick();
    check64("b2b_load2_imm_q", ifc.bus_imm_q, 64'h00000000000088D2);
    check2("b2b_load2_ctrl_q", ifc.ctrl_q, 2'b11);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sign_extender.md
SIGN_EXTENDER -- requirements
Module: SignExtender

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 The block SHALL have the following ports:
- CLK  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- In26  input  26  instruction bits [25:0]
- Ctrl  input  2  immediate format select
- En  input  1  load enable for the registered copy
- BusImm  output  64  combinational extended immediate
- BusImmQ  output  64  registered extended immediate
- CtrlQ  output  2  Ctrl value captured with BusImmQ

Function
REQ-003 BusImm SHALL be purely combinational from In26 and Ctrl, with zero-cycle latency and independent of CLK, Reset and En.
REQ-004 Ctrl=00 (I-type) SHALL zero-extend the field: BusImm = {52'b0, In26[21:10]}. In26[21] SHALL NOT be treated as a sign bit.
REQ-005 Ctrl=01 (D-type) SHALL sign-extend In26[20:12]: BusImm = {55{In26[20]}, In26[20:12]}.
REQ-006 Ctrl=10 (B-type) SHALL sign-extend In26[25:0]: BusImm = {38{In26[25]}, In26[25:0]}.
REQ-007 Ctrl=11 (CB-type) SHALL sign-extend In26[23:5]: BusImm = {45{In26[23]}, In26[23:5]}.
REQ-008 No format SHALL shift the result; word-offset scaling is the consumer's job.
REQ-009 In26 bits outside the selected field SHALL have no effect on BusImm.
REQ-010 On each rising CLK edge with Reset=0 and En=1, the block SHALL load BusImmQ with the current BusImm and CtrlQ with Ctrl (one-cycle latency).
REQ-011 On a rising CLK edge with Reset=0 and En=0, BusImmQ and CtrlQ SHALL hold their values.
REQ-012 Reset SHALL take priority over En.
REQ-013 Ctrl and In26 changes SHALL propagate to BusImm within the same cycle. BusImmQ SHALL reflect only the values present at the loading edge.

Reset
REQ-014 With Reset=1 at a rising CLK edge, BusImmQ SHALL become 64'h0 and CtrlQ SHALL become 2'b00.
REQ-015 Reset SHALL NOT affect BusImm.
REQ-016 Assertion of Reset in the middle of operation SHALL discard any pending load on that edge.
REQ-017 The first load after Reset deasserts SHALL occur on the next edge with En=1.

Verification
REQ-018 In26=26'h111A55, Ctrl=00 -> BusImm=64'h446. With In26[21] forced to 1 -> BusImm=64'hC46 (zero-extended).
REQ-019 In26=26'h111A55, Ctrl=01 -> BusImm=64'hFFFFFFFFFFFFFF11. With In26[20] forced to 0 -> BusImm=64'h11.
REQ-020 In26=26'h111A55, Ctrl=10 -> BusImm=64'h111A55. With In26[25] forced to 1 -> BusImm=64'hFFFFFFFFFE111A55.
REQ-021 In26=26'h111A55, Ctrl=11 -> BusImm=64'h88D2. With In26[23] forced to 1 -> BusImm=64'hFFFFFFFFFFFC88D2.
REQ-022 Registered path:
- Reset=1 for one edge -> BusImmQ=0, CtrlQ=00.
- Then Reset=0, En=1, Ctrl=10, In26=26'h2111A55 -> after one edge, BusImmQ=64'hFFFFFFFFFE111A55 and CtrlQ=10.
- Then En=0 with new inputs -> BusImmQ unchanged.
REQ-023 Reset=1 together with En=1 -> BusImmQ=0 after the edge, while BusImm still tracks the inputs.
